// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO management master; valid/ready request in, one-clk response pulse out.
// Optional feature macro MDIO_PRE_SUPPRESS_EN adds req_pre_sup, which skips the preamble for one frame.
module mdio_master #(
  parameter int unsigned CLK_DIV = 20,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rd,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
`ifdef MDIO_PRE_SUPPRESS_EN
  input  logic        req_pre_sup,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);
  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned CNT_W = 6;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_END
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic             rd_q;
  logic [4:0]       phy_q;
  logic [4:0]       reg_q;
  logic [15:0]      wdata_q;
  logic [15:0]      rdata_sh;
  logic             err_sh;

  state_t           nxt_state_c;
  logic [CNT_W-1:0] nxt_cnt_c;
  logic             bit_o_c;
  logic             bit_oe_c;
  logic             use_pre_c;

`ifdef MDIO_PRE_SUPPRESS_EN
  assign use_pre_c = (PRE_LEN != 0) && !req_pre_sup;
`else
  assign use_pre_c = (PRE_LEN != 0);
`endif

  // Which bit follows the current one: field state plus index within the field.
  always_comb begin
    nxt_state_c = state;
    nxt_cnt_c   = cnt + CNT_W'(1);
    case (state)
      S_IDLE:  begin nxt_state_c = use_pre_c ? S_PRE : S_ST; nxt_cnt_c = '0; end
      S_PRE:   if (cnt == PRE_LAST)    begin nxt_state_c = S_ST;    nxt_cnt_c = '0; end
      S_ST:    if (cnt == CNT_W'(1))   begin nxt_state_c = S_OP;    nxt_cnt_c = '0; end
      S_OP:    if (cnt == CNT_W'(1))   begin nxt_state_c = S_PHYAD; nxt_cnt_c = '0; end
      S_PHYAD: if (cnt == CNT_W'(4))   begin nxt_state_c = S_REGAD; nxt_cnt_c = '0; end
      S_REGAD: if (cnt == CNT_W'(4))   begin nxt_state_c = S_TA;    nxt_cnt_c = '0; end
      S_TA:    if (cnt == CNT_W'(1))   begin nxt_state_c = S_DATA;  nxt_cnt_c = '0; end
      S_DATA:  if (cnt == CNT_W'(15))  begin nxt_state_c = S_END;   nxt_cnt_c = '0; end
      default: begin nxt_state_c = S_IDLE; nxt_cnt_c = '0; end
    endcase
  end

  // Pad value for the upcoming bit; released lines idle at 1.
  always_comb begin
    bit_o_c  = 1'b1;
    bit_oe_c = 1'b1;
    case (nxt_state_c)
      S_PRE:   bit_o_c = 1'b1;
      S_ST:    bit_o_c = nxt_cnt_c[0];
      S_OP:    bit_o_c = rd_q ^ nxt_cnt_c[0];
      S_PHYAD: bit_o_c = phy_q[3'(3'd4 - nxt_cnt_c[2:0])];
      S_REGAD: bit_o_c = reg_q[3'(3'd4 - nxt_cnt_c[2:0])];
      S_TA: begin
        bit_o_c  = rd_q | ~nxt_cnt_c[0];
        bit_oe_c = ~rd_q;
      end
      S_DATA: begin
        bit_o_c  = rd_q | wdata_q[4'(4'd15 - nxt_cnt_c[3:0])];
        bit_oe_c = ~rd_q;
      end
      default: begin
        bit_o_c  = 1'b1;
        bit_oe_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      div       <= '0;
      rd_q      <= 1'b0;
      phy_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rdata_sh  <= '0;
      err_sh    <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == S_IDLE) begin
        mdc <= 1'b0;
        div <= '0;
        if (req_valid && req_ready) begin
          req_ready <= 1'b0;
          busy      <= 1'b1;
          rd_q      <= req_rd;
          phy_q     <= req_phy;
          reg_q     <= req_reg;
          wdata_q   <= req_wdata;
          rdata_sh  <= '0;
          err_sh    <= 1'b0;
          state     <= nxt_state_c;
          cnt       <= nxt_cnt_c;
          mdio_o    <= bit_o_c;
          mdio_oe   <= bit_oe_c;
        end else begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      end else if (div == DIV_LAST) begin
        div <= '0;
        mdc <= ~mdc;
        if (!mdc) begin
          // Rising MDC: the PHY's bit is stable, capture it.
          if (state == S_TA && cnt == CNT_W'(1) && rd_q) err_sh <= mdio_i;
          if (state == S_DATA && rd_q) rdata_sh <= {rdata_sh[14:0], mdio_i};
        end else begin
          state   <= nxt_state_c;
          cnt     <= nxt_cnt_c;
          mdio_o  <= bit_o_c;
          mdio_oe <= bit_oe_c;
          if (state == S_END) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_sh;
            rsp_err   <= err_sh;
          end
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: two MDIO masters (32-bit and no preamble) against a bit-level frame model and PHY model.
module tb_mdio_master;
  localparam int unsigned DIV_A = 2;
  localparam int unsigned PRE_A = 32;
  localparam int unsigned DIV_B = 3;
  localparam int unsigned PRE_B = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_rd = 1'b0;
  logic [4:0] req_phy = '0;
  logic [4:0] req_reg = '0;
  logic [15:0] req_wdata = '0;
  logic va = 1'b0, vb = 1'b0;
  logic ready_a, rv_a, err_a, busy_a, mdc_a, o_a, oe_a, mi_a;
  logic ready_b, rv_b, err_b, busy_b, mdc_b, o_b, oe_b, mi_b;
  logic [15:0] rdata_a, rdata_b;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int acc = 0;
  int last_rsp = 0;
  int st = 0;
  int rv_cnt_a = 0;
  logic sel = 1'b0;
  logic [1:0] mon_a[$];
  logic [1:0] mon_b[$];

  logic phy_present = 1'b0;
  logic phy_rd = 1'b0;
  logic [15:0] phy_data = '0;
  logic phy_en = 1'b0;
  logic phy_bit = 1'b1;

  logic ready_s, rv_s, busy_s, err_s;
  logic [15:0] rdata_s;
  assign ready_s = sel ? ready_b : ready_a;
  assign rv_s    = sel ? rv_b    : rv_a;
  assign busy_s  = sel ? busy_b  : busy_a;
  assign err_s   = sel ? err_b   : err_a;
  assign rdata_s = sel ? rdata_b : rdata_a;

  assign mi_a = oe_a ? o_a : (phy_en ? phy_bit : 1'b1);
  assign mi_b = oe_b ? o_b : 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rv_a) rv_cnt_a <= rv_cnt_a + 1;
  always @(posedge mdc_a) mon_a.push_back({oe_a, o_a});
  always @(posedge mdc_b) mon_b.push_back({oe_b, o_b});

  // PHY: after MDC falls into bit k, drive TA2=0 then data MSB first on reads.
  always @(negedge mdc_a) begin
    int k;
    int idx;
    k = mon_a.size() - st;
    idx = 31 + int'(PRE_A) - k;
    phy_en  <= phy_present && phy_rd && (k >= int'(PRE_A) + 15) && (k <= int'(PRE_A) + 31);
    phy_bit <= (k >= int'(PRE_A) + 16) ? phy_data[4'(idx)] : 1'b0;
  end

  mdio_master #(.CLK_DIV(DIV_A), .PRE_LEN(PRE_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(va), .req_ready(ready_a), .req_rd(req_rd),
    .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
`ifdef MDIO_PRE_SUPPRESS_EN
    .req_pre_sup(1'b0),
`endif
    .rsp_valid(rv_a), .rsp_rdata(rdata_a), .rsp_err(err_a), .busy(busy_a),
    .mdc(mdc_a), .mdio_o(o_a), .mdio_oe(oe_a), .mdio_i(mi_a)
  );

  mdio_master #(.CLK_DIV(DIV_B), .PRE_LEN(PRE_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(vb), .req_ready(ready_b), .req_rd(req_rd),
    .req_phy(req_phy), .req_reg(req_reg), .req_wdata(req_wdata),
`ifdef MDIO_PRE_SUPPRESS_EN
    .req_pre_sup(1'b0),
`endif
    .rsp_valid(rv_b), .rsp_rdata(rdata_b), .rsp_err(err_b), .busy(busy_b),
    .mdc(mdc_b), .mdio_o(o_b), .mdio_oe(oe_b), .mdio_i(mi_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request (called at a negedge) and return at the negedge after acceptance.
  task automatic launch(input bit rd, input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd);
    int n;
    req_rd = rd; req_phy = phy; req_reg = rg; req_wdata = wd;
    if (sel) vb = 1'b1; else va = 1'b1;
    n = 0;
    while (!ready_s && n < 4000) begin @(negedge clk); n++; end
    check("accept_wait", 32'(ready_s), 32'd1);
    st = sel ? mon_b.size() : mon_a.size();
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    va = 1'b0; vb = 1'b0;
    req_rd = ~rd; req_phy = 5'($urandom); req_reg = 5'($urandom); req_wdata = 16'($urandom);
  endtask

  // Wait for the response and compare it and the serialised frame with the model.
  task automatic complete(input bit rd, input logic [4:0] phy, input logic [4:0] rg,
                          input logic [15:0] wd, input bit present, input logic [15:0] pdata);
    int n, pre, tbit, nb;
    logic [1:0] exp_q[$];
    logic [1:0] got;
    pre  = sel ? int'(PRE_B) : int'(PRE_A);
    tbit = 2 * (sel ? int'(DIV_B) : int'(DIV_A));
    for (int i = 0; i < pre; i++) exp_q.push_back(2'b11);
    exp_q.push_back(2'b10); exp_q.push_back(2'b11);
    exp_q.push_back({1'b1, rd}); exp_q.push_back({1'b1, ~rd});
    for (int i = 4; i >= 0; i--) exp_q.push_back({1'b1, phy[i]});
    for (int i = 4; i >= 0; i--) exp_q.push_back({1'b1, rg[i]});
    if (rd) begin exp_q.push_back(2'b01); exp_q.push_back(2'b01); end
    else    begin exp_q.push_back(2'b11); exp_q.push_back(2'b10); end
    for (int i = 15; i >= 0; i--) exp_q.push_back(rd ? 2'b01 : {1'b1, wd[i]});
    exp_q.push_back(2'b01);

    n = 0;
    while (!rv_s && n < 4000) begin
      @(negedge clk); n++;
      if (!rv_s && (n % 64 == 1)) begin
        check("busy_mid", 32'(busy_s), 32'd1);
        check("ready_mid", 32'(ready_s), 32'd0);
      end
    end
    check("rsp_seen", 32'(rv_s), 32'd1);
    check("latency", 32'(cyc - acc), 32'((pre + 33) * tbit));
    check("busy_at_rsp", 32'(busy_s), 32'd1);
    check("rsp_err", 32'(err_s), 32'(rd && !present));
    if (rd) check("rsp_rdata", 32'(rdata_s), 32'(present ? pdata : 16'hFFFF));
    last_rsp = cyc;
    nb = (sel ? mon_b.size() : mon_a.size()) - st;
    check("frame_bits", 32'(nb), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < nb; i++) begin
      got = sel ? mon_b[st + i] : mon_a[st + i];
      check($sformatf("oe_bit%0d", i), 32'(got[1]), 32'(exp_q[i][1]));
      if (exp_q[i][1]) check($sformatf("o_bit%0d", i), 32'(got[0]), 32'(exp_q[i][0]));
    end
    @(negedge clk);
    check("rsp_pulse", 32'(rv_s), 32'd0);
    check("busy_fall", 32'(busy_s), 32'd0);
    check("ready_rise", 32'(ready_s), 32'd1);
  endtask

  initial begin
    logic rd;
    logic [4:0] p, r;
    logic [15:0] w, d;
    logic [4:0] p2, r2;
    logic [15:0] d2;
    int rvc, n;

    repeat (3) @(negedge clk);
    check("rst_mdc", 32'(mdc_a), 32'd0);
    check("rst_mdio_o", 32'(o_a), 32'd1);
    check("rst_mdio_oe", 32'(oe_a), 32'd0);
    check("rst_rsp_valid", 32'(rv_a), 32'd0);
    check("rst_rsp_rdata", 32'(rdata_a), 32'd0);
    check("rst_rsp_err", 32'(err_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed write with a 32-bit preamble.
    sel = 1'b0;
    launch(1'b0, 5'h10, 5'h00, 16'h8140);
    complete(1'b0, 5'h10, 5'h00, 16'h8140, 1'b0, 16'h0);

    // Read with a PHY answering 0x1234.
    p = 5'($urandom); r = 5'($urandom);
    phy_present = 1'b1; phy_rd = 1'b1; phy_data = 16'h1234;
    launch(1'b1, p, r, 16'($urandom));
    complete(1'b1, p, r, 16'h0, 1'b1, 16'h1234);

    // Read with no PHY: pull-up gives all ones and a turnaround error, still one pulse.
    phy_present = 1'b0;
    rvc = rv_cnt_a;
    launch(1'b1, p, r, 16'h0);
    complete(1'b1, p, r, 16'h0, 1'b0, 16'h0);
    check("single_pulse", 32'(rv_cnt_a - rvc), 32'd1);

    for (int it = 0; it < 4; it++) begin
      rd = 1'($urandom); p = 5'($urandom); r = 5'($urandom); w = 16'($urandom); d = 16'($urandom);
      phy_present = 1'($urandom); phy_rd = rd; phy_data = d;
      launch(rd, p, r, w);
      complete(rd, p, r, w, phy_present, d);
    end

    // Back-to-back: second request held valid during the first frame.
    p = 5'($urandom); r = 5'($urandom); w = 16'($urandom);
    p2 = 5'($urandom); r2 = 5'($urandom); d2 = 16'($urandom);
    phy_present = 1'b1; phy_rd = 1'b0;
    launch(1'b0, p, r, w);
    req_rd = 1'b1; req_phy = p2; req_reg = r2; req_wdata = 16'($urandom); va = 1'b1;
    complete(1'b0, p, r, w, 1'b0, 16'h0);
    phy_rd = 1'b1; phy_data = d2;
    launch(1'b1, p2, r2, 16'h0);
    check("b2b_accept", 32'(acc - last_rsp), 32'd2);
    complete(1'b1, p2, r2, 16'h0, 1'b1, d2);

    // Reset pulse in the middle of the data field.
    phy_present = 1'b1; phy_rd = 1'b1; phy_data = 16'($urandom);
    launch(1'b1, 5'($urandom), 5'($urandom), 16'h0);
    n = 0;
    while ((mon_a.size() - st) < int'(PRE_A) + 20 && n < 4000) begin @(negedge clk); n++; end
    check("reach_data", 32'(mon_a.size() - st >= int'(PRE_A) + 20), 32'd1);
    rvc = rv_cnt_a;
    #2 rst_n = 1'b0;
    #1;
    check("abort_mdc", 32'(mdc_a), 32'd0);
    check("abort_oe", 32'(oe_a), 32'd0);
    check("abort_mdio_o", 32'(o_a), 32'd1);
    check("abort_busy", 32'(busy_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("abort_no_rsp", 32'(rv_cnt_a - rvc), 32'd0);
    p = 5'($urandom); r = 5'($urandom); w = 16'($urandom);
    launch(1'b0, p, r, w);
    complete(1'b0, p, r, w, 1'b0, 16'h0);

    // No-preamble instance with an odd divider.
    sel = 1'b1;
    p = 5'($urandom); r = 5'($urandom); w = 16'($urandom);
    launch(1'b0, p, r, w);
    complete(1'b0, p, r, w, 1'b0, 16'h0);
    launch(1'b1, p, r, 16'h0);
    complete(1'b1, p, r, 16'h0, 1'b0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
